shift_seq_ctrl: RTL
===================

// Module: shift_seq_ctrl
// PURPOSE
//   Command sequencer for an 8-bit left/right shift register datapath.
//   Accepts {data, direction, amount} over a valid/ready handshake, loads the register,
//   shifts it one bit per clock for the requested number of cycles, then returns the result.
//   Sits between a command-issuing master and the shift datapath; one command in flight.
// PARAMETERS
//   WIDTH  8  datapath width in bits
//   CNT_W  4  width of the shift-amount field and counter; must hold WIDTH
// PORTS
//   clk         in   1      rising-edge clock
//   reset_n     in   1      asynchronous active-low reset
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      block can accept a command
//   cmd_data    in   WIDTH  value to load
//   cmd_dir     in   1      0 = shift left (toward MSB), 1 = shift right
//   cmd_amount  in   CNT_W  number of single-bit shifts, 0..2**CNT_W-1
//   cmd_rotate  in   1      rotate mode (only honoured with SHIFT_SEQ_ROTATE_EN)
//   res_valid   out  1      result available
//   res_ready   in   1      consumer takes result
//   res_data    out  WIDTH  shifted result
//   busy        out  1      high in any state other than IDLE
// BEHAVIOUR
//   - Reset (async, reset_n low): state IDLE; register, counter, res_data = 0;
//     cmd_ready = 1; res_valid = 0; busy = 0. Applies mid-command; the command is dropped.
//   - FSM states: IDLE, SHIFT, DONE. cmd_ready = (state==IDLE); res_valid = (state==DONE).
//   - IDLE: on cmd_valid && cmd_ready edge (the "accept edge"): register <= cmd_data;
//     dir/rotate latched; counter <= min(cmd_amount, WIDTH) (saturation).
//     Next state is SHIFT if the saturated amount > 0, otherwise DONE.
//   - SHIFT: on each edge, shift one bit in the latched direction (zero fill) and decrement
//     the counter. The edge that decrements the counter from 1 to 0 moves the FSM to DONE.
//   - Latency: count the accept edge as edge 0. res_valid is high after edge N, where N is
//     the saturated amount. For N = 0 this is immediately after the accept edge.
//   - DONE: res_data = register, held stable while res_valid is high.
//     On an edge with res_ready = 1, go to IDLE. A new command can be accepted one cycle
//     later (no same-cycle result/command overlap).
//   - cmd_* inputs are ignored outside IDLE. Changes to cmd_* after acceptance have no effect.
//   - res_ready outside DONE is ignored. Back-pressure holds DONE indefinitely.
// CONFIGURATION
//   SHIFT_SEQ_ROTATE_EN defined: when cmd_rotate = 1 at accept, the bit shifted out
//     re-enters at the opposite end (rotate left/right). Saturation still applies.
//   SHIFT_SEQ_ROTATE_EN undefined: cmd_rotate is ignored; zero fill always.
//   The port list is identical in both builds.
// STRUCTURE
//   - Package shift_seq_pkg: state enum (IDLE, SHIFT, DONE), DIR_LEFT = 1'b0,
//     DIR_RIGHT = 1'b1, default WIDTH/CNT_W constants.
//   - Sub-module shift_seq_datapath: WIDTH-bit register with load, shift-enable, direction
//     and rotate inputs, plus async active-low reset.
//   - FSM and down-counter stay in shift_seq_ctrl.
// TESTING
//   1. Reset: reset_n low -> cmd_ready = 1, res_valid = 0, busy = 0, res_data = 8'h00.
//   2. cmd_data = 8'hA5, dir = 0, amount = 3 -> res_valid after edge 3, res_data = 8'h28.
//      busy is high throughout.
//   3. 8'hA5, dir = 1, amount = 2 -> res_data = 8'h29.
//      Hold res_ready = 0 for 5 cycles -> res_valid and res_data stay stable, cmd_ready = 0.
//   4. amount = 0 with 8'h3C -> res_valid right after the accept edge, res_data = 8'h3C.
//      amount = 12 with 8'hFF -> 8 shift cycles, res_data = 8'h00.
//   5. Pulse reset_n low during the SHIFT of 8'hA5 << 5 -> immediate IDLE and zero outputs.
//      The next command 8'h01 << 1 returns 8'h02.
//   6. With SHIFT_SEQ_ROTATE_EN: 8'hA5, rotate left 3 -> 8'h2D.
//      Without the macro, the same command -> 8'h28.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_seq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_datapath.sv
// WIDTH-bit shift register: parallel load, one-bit shift per enabled cycle, zero fill or rotate.
// Latency: load and each shift take effect on the next rising edge of clk.
// Backpressure: none; the register only moves when the controller asserts load or shift_en.
// Ports: clk, reset_n (async active-low), load/load_data, shift_en, dir (0 left, 1 right),
//        rotate (recirculate the outgoing bit), q (register contents).
module shift_seq_datapath
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             rotate,
    output logic [WIDTH-1:0] q
);

    // Bit entering the vacated end: the bit leaving the other end when rotating, else zero.
    logic fill_lsb;
    logic fill_msb;

    assign fill_lsb = rotate & q[WIDTH-1];
    assign fill_msb = rotate & q[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            if (dir == DIR_LEFT) begin
                q <= {q[WIDTH-2:0], fill_lsb};
            end else begin
                q <= {fill_msb, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer: accepts {data, dir, amount}, shifts one bit per clock, returns the result.
// Latency: res_valid rises after edge N (accept edge = edge 0), N = min(amount, WIDTH).
// Backpressure: one command in flight; DONE is held until res_ready, cmd_ready low while busy.
// Ports: clk, reset_n (async active-low), cmd_valid/cmd_ready/cmd_data/cmd_dir/cmd_amount/
//        cmd_rotate, res_valid/res_ready/res_data, busy.
// Build option: SHIFT_SEQ_ROTATE_EN enables rotate mode via cmd_rotate; otherwise zero fill.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_amount,
    input  logic             cmd_rotate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SAT_AMT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] amt_sat;
    logic             dir_q;
    logic             rot_q;
    logic             rot_in;
    logic             accept;
    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] reg_q;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign rot_in = cmd_rotate;
`else
    // Rotate request has no effect in this build; the port stays for a uniform interface.
    logic unused_rotate;
    assign unused_rotate = cmd_rotate;
    assign rot_in        = 1'b0;
`endif

    // Shifting more than WIDTH times gives the same zero-fill result as WIDTH, so cap the count.
    assign amt_sat = (cmd_amount > SAT_AMT) ? SAT_AMT : cmd_amount;
    assign accept  = cmd_valid && (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    load       = 1'b1;
                    next_state = (amt_sat != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                // The final shift happens on the same edge that takes us to DONE.
                if (cnt == CNT_ONE) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            dir_q <= DIR_LEFT;
            rot_q <= 1'b0;
        end else if (accept) begin
            cnt   <= amt_sat;
            dir_q <= cmd_dir;
            rot_q <= rot_in;
        end else if (shift_en) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    shift_seq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (cmd_data),
        .shift_en  (shift_en),
        .dir       (dir_q),
        .rotate    (rot_q),
        .q         (reg_q)
    );

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = reg_q;

endmodule
